// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared definitions for the frame-locked audio sequencer:
//                FSM state encoding, note codes, the note -> half-period
//                table (clk = 25.175 MHz) and the default sequence ROM.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One sequence table entry: {note[3:0], dur[1:0]}
    typedef struct packed {
        logic [3:0] note;
        logic [1:0] dur;
    } entry_t;

    // Note codes 1..15 are the chromatic scale C4..D5; 0 is a rest.
    localparam logic [3:0] C_NOTE_REST = 4'd0;
    localparam logic [3:0] C_NOTE_C4   = 4'd1;
    localparam logic [3:0] C_NOTE_D4   = 4'd3;
    localparam logic [3:0] C_NOTE_E4   = 4'd5;
    localparam logic [3:0] C_NOTE_F4   = 4'd6;
    localparam logic [3:0] C_NOTE_G4   = 4'd8;
    localparam logic [3:0] C_NOTE_A4   = 4'd10;
    localparam logic [3:0] C_NOTE_B4   = 4'd12;
    localparam logic [3:0] C_NOTE_C5   = 4'd13;

    // Half period in clk cycles: round(25_175_000 / (2 * f_note)).
    // The rest entry is a dummy non-zero value; its output is gated off.
    localparam logic [15:0] C_HALF_PERIOD [16] = '{
        16'd1,     16'd48113, 16'd45413, 16'd42864,
        16'd40457, 16'd38187, 16'd36044, 16'd34021,
        16'd32111, 16'd30309, 16'd28608, 16'd27003,
        16'd25487, 16'd24056, 16'd22706, 16'd21432
    };

    // Default tune; step length = (dur + 1) beats.
    localparam entry_t C_SEQ_ROM [16] = '{
        {C_NOTE_A4,   2'd0}, {C_NOTE_C5,   2'd1}, {C_NOTE_REST, 2'd1}, {C_NOTE_E4,   2'd0},
        {C_NOTE_G4,   2'd0}, {C_NOTE_C4,   2'd2}, {C_NOTE_D4,   2'd0}, {C_NOTE_F4,   2'd1},
        {C_NOTE_A4,   2'd0}, {C_NOTE_B4,   2'd0}, {C_NOTE_C5,   2'd1}, {C_NOTE_REST, 2'd0},
        {C_NOTE_G4,   2'd0}, {C_NOTE_E4,   2'd0}, {C_NOTE_D4,   2'd1}, {C_NOTE_C4,   2'd3}
    };

endpackage : audio_pkg
`default_nettype wire

// File: rtl/note_rom.sv
`default_nettype none
// ============================================================================
//  Module      : note_rom
//  Description : Purely combinational lookup: step index -> {note, dur},
//                note -> tone half period.
//  Ports       : step        in   sequence step index
//                note        out  note code (0 = rest)
//                dur         out  duration code, step lasts dur+1 beats
//                half_period out  half period of the note in clk cycles
//  Revision    : 1.0  initial release
// ============================================================================
module note_rom
    import audio_pkg::*;
#(
    parameter int SEQ_LEN = 16,
    parameter int DIV_W   = 16
) (
    input  logic [$clog2(SEQ_LEN)-1:0] step,
    output logic [3:0]                 note,
    output logic [1:0]                 dur,
    output logic [DIV_W-1:0]           half_period
);

    entry_t w_entry;

    assign w_entry     = C_SEQ_ROM[4'(step)];
    assign note        = w_entry.note;
    assign dur         = w_entry.dur;
    assign half_period = DIV_W'(C_HALF_PERIOD[w_entry.note]);

endmodule : note_rom
`default_nettype wire

// File: rtl/audio_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sequencer
//  Description : Frame-locked music sequencer. Steps through the note ROM,
//                each step lasting (dur+1)*FRAMES_PER_BEAT frames with the
//                final GAP_FRAMES silent, and drives a square-wave tone.
//  Ports       : clk        in   pixel clock
//                rst_n      in   asynchronous reset, active low
//                frame_tick in   one-clk pulse per video frame
//                enable     in   1 = play, 0 = stop immediately
//                loop       in   1 = wrap to step 0 after the last step
//                audio_pwm  out  registered square-wave audio
//                step       out  current step index
//                playing    out  1 while in TONE or GAP
//                done       out  one-clk pulse at end of a non-looped run
//  Revision    : 1.0  initial release
// ============================================================================
module audio_sequencer
    import audio_pkg::*;
#(
    parameter int SEQ_LEN         = 16,
    parameter int FRAMES_PER_BEAT = 8,
    parameter int GAP_FRAMES      = 1,
    parameter int DIV_W           = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic                       enable,
    input  logic                       loop,
    output logic                       audio_pwm,
    output logic [$clog2(SEQ_LEN)-1:0] step,
    output logic                       playing,
    output logic                       done
);

    localparam int                    C_STEP_W    = $clog2(SEQ_LEN);
    localparam int                    C_FCNT_W    = $clog2(4*FRAMES_PER_BEAT+1);
    localparam logic [C_STEP_W-1:0]   C_LAST_STEP = C_STEP_W'(SEQ_LEN-1);

    state_t                r_state, w_state_next;
    logic [C_STEP_W-1:0]   r_step, w_step_next;
    logic [C_FCNT_W-1:0]   r_frame_cnt, w_frame_cnt_next;
    logic [C_FCNT_W-1:0]   w_frame_inc, w_step_len, w_tone_len;
    logic                  w_load_tone, w_done_next, w_advance;

    // Attributes of the step being played, captured when the step starts.
    logic [3:0]            r_note, w_rom_note;
    logic [1:0]            r_dur, w_rom_dur;
    logic [DIV_W-1:0]      r_half_period, w_rom_half_period;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_sq;

    assign step        = r_step;
    assign w_step_len  = C_FCNT_W'((int'(r_dur) + 1) * FRAMES_PER_BEAT);
    assign w_tone_len  = w_step_len - C_FCNT_W'(GAP_FRAMES);
    assign w_frame_inc = r_frame_cnt + C_FCNT_W'(1);

    // The ROM looks up the step about to be entered, so the tone counter
    // can be loaded with the new pitch on the very edge the step begins.
    note_rom #(
        .SEQ_LEN     (SEQ_LEN),
        .DIV_W       (DIV_W)
    ) u_note_rom (
        .step        (w_step_next),
        .note        (w_rom_note),
        .dur         (w_rom_dur),
        .half_period (w_rom_half_period)
    );

    always_comb begin
        w_state_next     = r_state;
        w_step_next      = r_step;
        w_frame_cnt_next = r_frame_cnt;
        w_load_tone      = 1'b0;
        w_done_next      = 1'b0;
        w_advance        = 1'b0;

        if (!enable) begin
            // Stop wins over any same-cycle frame_tick.
            w_state_next     = ST_IDLE;
            w_step_next      = '0;
            w_frame_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        w_state_next     = ST_TONE;
                        w_step_next      = '0;
                        w_frame_cnt_next = '0;
                        w_load_tone      = 1'b1;
                    end
                end
                ST_TONE, ST_GAP: begin
                    if (frame_tick) begin
                        // Checking the full length first lets GAP_FRAMES=0
                        // skip the GAP state entirely.
                        if (w_frame_inc == w_step_len) begin
                            w_advance = 1'b1;
                        end else begin
                            w_frame_cnt_next = w_frame_inc;
                            if (r_state == ST_TONE && w_frame_inc == w_tone_len) begin
                                w_state_next = ST_GAP;
                            end
                        end
                    end
                end
                default: begin
                    w_state_next     = ST_IDLE;
                    w_step_next      = '0;
                    w_frame_cnt_next = '0;
                end
            endcase

            if (w_advance) begin
                w_frame_cnt_next = '0;
                if (r_step != C_LAST_STEP) begin
                    w_step_next  = r_step + C_STEP_W'(1);
                    w_state_next = ST_TONE;
                    w_load_tone  = 1'b1;
                end else if (loop) begin
                    w_step_next  = '0;
                    w_state_next = ST_TONE;
                    w_load_tone  = 1'b1;
                end else begin
                    w_step_next  = '0;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_step        <= '0;
            r_frame_cnt   <= '0;
            r_note        <= '0;
            r_dur         <= '0;
            r_half_period <= '0;
            r_div_cnt     <= '0;
            r_sq          <= 1'b0;
            audio_pwm     <= 1'b0;
            playing       <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_frame_cnt <= w_frame_cnt_next;
            done        <= w_done_next;
            playing     <= (w_state_next != ST_IDLE);

            if (w_load_tone) begin
                r_note        <= w_rom_note;
                r_dur         <= w_rom_dur;
                r_half_period <= w_rom_half_period;
                r_div_cnt     <= w_rom_half_period - DIV_W'(1);
                r_sq          <= 1'b0;
            end else if (r_state == ST_TONE) begin
                if (r_div_cnt == '0) begin
                    r_sq      <= ~r_sq;
                    r_div_cnt <= r_half_period - DIV_W'(1);
                end else begin
                    r_div_cnt <= r_div_cnt - DIV_W'(1);
                end
            end

            audio_pwm <= r_sq & (r_state == ST_TONE) & (r_note != C_NOTE_REST);
        end
    end

endmodule : audio_sequencer
`default_nettype wire

// File: tb/tb_audio_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_sequencer
//  Description : Self-checking bench for audio_sequencer. A frame/step level
//                reference model predicts step, playing, done and audio_pwm
//                every clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_sequencer;

    localparam int FPB = 8;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       enable;
    logic       loop;
    logic       audio_pwm;
    logic [3:0] step;
    logic       playing;
    logic       done;

    always #5 clk = ~clk;

    audio_sequencer #(
        .SEQ_LEN         (16),
        .FRAMES_PER_BEAT (FPB),
        .GAP_FRAMES      (GAP),
        .DIV_W           (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (enable),
        .loop       (loop),
        .audio_pwm  (audio_pwm),
        .step       (step),
        .playing    (playing),
        .done       (done)
    );

    // Expected tune: note codes (10 = A4, 13 = C5, 0 = rest ...) and durations.
    int tb_note [16] = '{10, 13, 0, 5, 8, 1, 3, 6, 10, 12, 13, 0, 8, 5, 3, 1};
    int tb_dur  [16] = '{ 0,  1, 1, 0, 0, 2, 0, 1,  0,  0,  1, 0, 0, 0, 1, 3};
    int tb_hp   [16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    // Reference model
    bit m_act;
    int m_step, m_frames, m_age;
    bit m_done, m_audio;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    function automatic int step_len(input int s);
        return (tb_dur[s] + 1) * FPB;
    endfunction

    task automatic model_reset();
        m_act = 0; m_step = 0; m_frames = 0; m_age = 0; m_done = 0; m_audio = 0;
    endtask

    task automatic model_edge(input bit en, input bit tk, input bit lp);
        bit pre_tone;
        bit pre_sq;
        int pre_note;
        pre_note = tb_note[m_step];
        pre_tone = m_act && (m_frames < step_len(m_step) - GAP);
        pre_sq   = (pre_note != 0) && (((m_age / tb_hp[pre_note]) % 2) == 1);
        m_audio  = pre_tone && pre_sq;
        m_done   = 0;
        if (!en) begin
            m_act = 0; m_step = 0; m_frames = 0;
        end else if (!m_act) begin
            if (tk) begin
                m_act = 1; m_step = 0; m_frames = 0; m_age = 0;
            end
        end else begin
            m_age++;
            if (tk) begin
                m_frames++;
                if (m_frames == step_len(m_step)) begin
                    m_frames = 0;
                    m_age    = 0;
                    if (m_step < 15) begin
                        m_step++;
                    end else if (lp) begin
                        m_step = 0;
                    end else begin
                        m_act = 0; m_step = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit tk);
        frame_tick = tk;
        @(posedge clk);
        model_edge(enable, tk, loop);
        cyc_cnt++;
        #1;
        frame_tick = 1'b0;
        check_eq("step",    32'(step),      32'(m_step));
        check_eq("playing", 32'(playing),   32'(m_act));
        check_eq("done",    32'(done),      32'(m_done));
        check_eq("audio",   32'(audio_pwm), 32'(m_audio));
    endtask

    task automatic run_frame(input int spacing);
        repeat (spacing) cyc(1'b0);
        cyc(1'b1);
    endtask

    initial begin
        int start_cyc;
        int rise_at;
        int fall_at;
        int guard;
        bit done_seen;

        for (int n = 1; n < 16; n++) begin
            real f;
            f = 440.0 * (2.0 ** ((n - 10) / 12.0));
            tb_hp[n] = $rtoi(25175000.0 / (2.0 * f) + 0.5);
        end
        tb_hp[0] = 1;

        rst_n = 1'b0; enable = 1'b0; loop = 1'b0; frame_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_step",    32'(step),      0);
        check_eq("rst_playing", 32'(playing),   0);
        check_eq("rst_done",    32'(done),      0);
        check_eq("rst_audio",   32'(audio_pwm), 0);
        rst_n = 1'b1;

        // Stays idle until enable && frame_tick
        cyc(1'b1); cyc(1'b1);
        enable = 1'b1;
        repeat (3) cyc(1'b0);

        // A4 on step 0 with long frames so the tone is visible
        cyc(1'b1);
        start_cyc = cyc_cnt;
        rise_at = -1; fall_at = -1;
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 8199; k++) begin
                cyc(1'b0);
                if (audio_pwm === 1'b1 && rise_at < 0) rise_at = cyc_cnt - start_cyc;
                if (audio_pwm === 1'b0 && rise_at >= 0 && fall_at < 0) fall_at = cyc_cnt - start_cyc;
            end
            cyc(1'b1);
        end
        check_eq("a4_first_rise", 32'(rise_at), 28609);
        check_eq("a4_first_fall", 32'(fall_at), 57217);
        check_eq("gap_step", 32'(step), 0);
        repeat (8199) cyc(1'b0);
        check_eq("gap_audio", 32'(audio_pwm), 0);
        cyc(1'b1);
        check_eq("adv_step", 32'(step), 1);

        // Rest of the tune, no loop, until done
        done_seen = 0;
        guard = 0;
        while (!done_seen && guard < 400) begin
            run_frame($urandom_range(1, 5));
            if (m_done) done_seen = (done === 1'b1);
            guard++;
        end
        check_eq("done_seen", 32'(done_seen), 1);
        check_eq("done_playing", 32'(playing), 0);
        cyc(1'b0);
        check_eq("done_pulse_end", 32'(done), 0);

        // Looped run across the wrap
        loop = 1'b1;
        cyc(1'b1);
        for (int i = 0; i < 240; i++) run_frame($urandom_range(0, 3));

        // Disable coincident with a frame_tick while in GAP
        loop = 1'b0;
        guard = 0;
        while (!(m_act && m_frames >= step_len(m_step) - GAP) && guard < 100) begin
            run_frame($urandom_range(0, 2));
            guard++;
        end
        check_eq("reach_gap", 32'(guard < 100), 1);
        enable = 1'b0;
        cyc(1'b1);
        check_eq("gapdis_step",    32'(step),    0);
        check_eq("gapdis_playing", 32'(playing), 0);
        check_eq("gapdis_done",    32'(done),    0);

        // Disable mid-TONE, then re-enable
        enable = 1'b1;
        cyc(1'b1);
        for (int i = 0; i < 12; i++) run_frame(1);
        repeat (2) cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check_eq("dis_step", 32'(step), 0);
        check_eq("dis_playing", 32'(playing), 0);
        cyc(1'b0);
        check_eq("dis_audio", 32'(audio_pwm), 0);
        enable = 1'b1;
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        check_eq("reen_playing", 32'(playing), 1);

        // Asynchronous reset mid-TONE
        for (int i = 0; i < 12; i++) run_frame(1);
        cyc(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_step",    32'(step),      0);
        check_eq("arst_playing", 32'(playing),   0);
        check_eq("arst_audio",   32'(audio_pwm), 0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (3) cyc(1'b0);
        cyc(1'b1);

        // Random soak: ticks, enable and loop all random
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            loop = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_audio_sequencer
`default_nettype wire
